hdb3_decode: RTL

- Streaming HDB3 decoder: converts a ternary HDB3 symbol stream (signed 2-bit per symbol) back to a binary bit stream.
- Receive-side counterpart of the team's AMI/HDB3 encoder; sits between the line-symbol source and the bit sink.
- Detects bipolar violations (V) and removes the V and any B substituted before it, restoring the original four zeros.
- Flags illegal symbols and counts violations.

---
 rtl/hdb3_decode.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/hdb3_decode.sv
// Streaming HDB3 decoder that turns ternary line symbols into bits through a 4-entry buffer.
// Optional HDB3_STRICT_CHECK_EN adds substitution-pattern and V-alternation checks on code_err.
module hdb3_decode #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 sym_valid,
    input  logic [1:0]           sym_in,
    output logic                 sym_ready,
    input  logic                 flush,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic                 code_err,
    output logic [CNT_WIDTH-1:0] v_count
);
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Handshake: a symbol transfers on a rising edge where sym_valid && sym_ready.
    state_t               state;
    state_t               state_nxt;
    logic [3:0]           buf_q;
    logic [3:0]           buf_nxt;
    logic [2:0]           cnt_q;
    logic [2:0]           cnt_nxt;
    logic                 last_pol_q;
    logic                 last_pol_nxt;
    logic                 bit_out_nxt;
    logic                 bit_valid_nxt;
    logic                 code_err_nxt;
    logic [CNT_WIDTH-1:0] v_count_nxt;

    logic                 accept;
    logic                 sym_illegal;
    logic                 sym_nz;
    logic                 sym_pol;
    logic                 is_mark;
    logic                 is_viol;
    logic [3:0]           cleared;
    logic [2:0]           cnt_push;
    logic [1:0]           drain_idx;

`ifdef HDB3_STRICT_CHECK_EN
    logic                 sym_zero;
    logic [3:0]           zf_q;
    logic [3:0]           zf_nxt;
    logic [3:0]           il_q;
    logic [3:0]           il_nxt;
    logic                 lastv_pol_q;
    logic                 lastv_pol_nxt;
    logic                 lastv_seen_q;
    logic                 lastv_seen_nxt;
    logic                 strict_err;

    assign sym_zero = (sym_in == 2'b00);
`endif

    assign sym_ready   = (state != ST_DRAIN);
    assign accept      = sym_valid && sym_ready;
    assign sym_illegal = (sym_in == 2'b10);
    assign sym_nz      = sym_in[0];
    // Polarity bit: 1 = positive pulse, 0 = negative pulse.
    assign sym_pol     = ~sym_in[1];
    assign is_mark     = sym_nz && (sym_pol != last_pol_q);
    assign is_viol     = sym_nz && (sym_pol == last_pol_q);
    // Oldest valid entry sits at index count-1; count==4 wraps to index 3.
    assign drain_idx   = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_nxt     = state;
        buf_nxt       = buf_q;
        cnt_nxt       = cnt_q;
        last_pol_nxt  = last_pol_q;
        bit_out_nxt   = bit_out;
        bit_valid_nxt = 1'b0;
        code_err_nxt  = 1'b0;
        v_count_nxt   = v_count;
        cleared       = buf_q;
        cnt_push      = cnt_q;
`ifdef HDB3_STRICT_CHECK_EN
        zf_nxt         = zf_q;
        il_nxt         = il_q;
        lastv_pol_nxt  = lastv_pol_q;
        lastv_seen_nxt = lastv_seen_q;
        strict_err     = 1'b0;
`endif

        case (state)
            ST_FILL, ST_RUN: begin
                if (accept) begin
                    if (is_viol) begin
                        cleared[2:0] = 3'b000;
                    end
                    buf_nxt = {cleared[2:0], is_mark};
                    if (state == ST_RUN) begin
                        bit_out_nxt   = cleared[3];
                        bit_valid_nxt = 1'b1;
                    end else begin
                        cnt_push = cnt_q + 3'd1;
                    end
                    if (is_mark) begin
                        last_pol_nxt = sym_pol;
                    end
                    if (is_viol && (v_count != {CNT_WIDTH{1'b1}})) begin
                        v_count_nxt = v_count + CNT_WIDTH'(1);
                    end
                    if (sym_illegal) begin
                        code_err_nxt = 1'b1;
                    end
`ifdef HDB3_STRICT_CHECK_EN
                    zf_nxt = {zf_q[2:0], sym_zero};
                    il_nxt = {il_q[2:0], sym_illegal};
                    if (is_viol) begin
                        // A legal V follows 000 or B00, i.e. three buffered legal symbols.
                        if (!((cnt_q >= 3'd3) && zf_q[0] && zf_q[1] && !il_q[2])) begin
                            strict_err = 1'b1;
                        end
                        if (lastv_seen_q && (sym_pol == lastv_pol_q)) begin
                            strict_err = 1'b1;
                        end
                        lastv_pol_nxt  = sym_pol;
                        lastv_seen_nxt = 1'b1;
                    end
                    code_err_nxt = code_err_nxt | strict_err;
`endif
                end
                cnt_nxt = cnt_push;
                if (flush) begin
`ifdef HDB3_STRICT_CHECK_EN
                    lastv_seen_nxt = 1'b0;
`endif
                    if (cnt_push != 3'd0) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        last_pol_nxt = 1'b0;
                    end
                end else if (cnt_push == 3'd4) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q != 3'd0) begin
                    bit_out_nxt   = buf_q[drain_idx];
                    bit_valid_nxt = 1'b1;
                    cnt_nxt       = cnt_q - 3'd1;
                end
                if (cnt_q <= 3'd1) begin
                    state_nxt    = ST_FILL;
                    last_pol_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_FILL;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_FILL;
            buf_q      <= 4'b0000;
            cnt_q      <= 3'd0;
            last_pol_q <= 1'b0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            code_err   <= 1'b0;
            v_count    <= '0;
`ifdef HDB3_STRICT_CHECK_EN
            zf_q         <= 4'b0000;
            il_q         <= 4'b0000;
            lastv_pol_q  <= 1'b0;
            lastv_seen_q <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            buf_q      <= buf_nxt;
            cnt_q      <= cnt_nxt;
            last_pol_q <= last_pol_nxt;
            bit_out    <= bit_out_nxt;
            bit_valid  <= bit_valid_nxt;
            code_err   <= code_err_nxt;
            v_count    <= v_count_nxt;
`ifdef HDB3_STRICT_CHECK_EN
            zf_q         <= zf_nxt;
            il_q         <= il_nxt;
            lastv_pol_q  <= lastv_pol_nxt;
            lastv_seen_q <= lastv_seen_nxt;
`endif
        end
    end
endmodule
